// File: rtl/sbox_arbiter.sv
// Arbitrates key-expansion and sub_bytes lookups onto one shared S-box and routes each result back to its issuer.
// Optional build macro SBOX_RR_EN selects round-robin arbitration instead of keyexp-first fixed priority.
module sbox_arbiter #(
    parameter int unsigned SBOX_LAT = 1
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        clear,
    input  logic        keyexp_req,
    input  logic [31:0] keyexp_word,
    output logic        keyexp_gnt,
    output logic        keyexp_valid,
    output logic [31:0] keyexp_result,
    input  logic        sbytes_req,
    input  logic [31:0] sbytes_word,
    output logic        sbytes_gnt,
    output logic        sbytes_valid,
    output logic [31:0] sbytes_result,
    output logic [31:0] sbox_in,
    input  logic [31:0] sbox_out,
    output logic        busy
);

    localparam logic OWN_KEYEXP = 1'b0;
    localparam logic OWN_SBYTES = 1'b1;

    logic              gnt_any;
    logic [SBOX_LAT:0] tag_vld_q, tag_vld_d;
    logic [SBOX_LAT:0] tag_own_q, tag_own_d;
    logic              algn_vld, algn_own;
    logic [31:0]       keyexp_result_q, keyexp_result_d;
    logic [31:0]       sbytes_result_q, sbytes_result_d;

`ifdef SBOX_RR_EN
    logic rr_ptr_q, rr_ptr_d;

    always_comb begin
        keyexp_gnt = 1'b0;
        sbytes_gnt = 1'b0;
        rr_ptr_d   = rr_ptr_q;
        if (!clear) begin
            if (keyexp_req && sbytes_req) begin
                if (rr_ptr_q == OWN_KEYEXP) keyexp_gnt = 1'b1;
                else                        sbytes_gnt = 1'b1;
            end else begin
                keyexp_gnt = keyexp_req;
                sbytes_gnt = sbytes_req;
            end
        end
        // Pointer moves to whichever requester did not just win.
        if (keyexp_gnt)      rr_ptr_d = OWN_SBYTES;
        else if (sbytes_gnt) rr_ptr_d = OWN_KEYEXP;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) rr_ptr_q <= OWN_KEYEXP;
        else        rr_ptr_q <= rr_ptr_d;
    end
`else
    always_comb begin
        keyexp_gnt = !clear && keyexp_req;
        sbytes_gnt = !clear && sbytes_req && !keyexp_req;
    end
`endif

    always_comb begin
        gnt_any = keyexp_gnt || sbytes_gnt;
        sbox_in = '0;
        if (keyexp_gnt)      sbox_in = keyexp_word;
        else if (sbytes_gnt) sbox_in = sbytes_word;
    end

    always_comb begin
        tag_vld_d    = '0;
        tag_own_d    = '0;
        tag_vld_d[0] = gnt_any;
        tag_own_d[0] = sbytes_gnt ? OWN_SBYTES : OWN_KEYEXP;
        for (int unsigned i = 1; i <= SBOX_LAT; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_own_d[i] = tag_own_q[i-1];
        end
        if (clear) tag_vld_d = '0;
    end

    // Tag that lines up with the word currently on sbox_out.
    generate
        if (SBOX_LAT == 0) begin : g_comb_sbox
            assign algn_vld = gnt_any;
            assign algn_own = sbytes_gnt ? OWN_SBYTES : OWN_KEYEXP;
        end else begin : g_pipe_sbox
            assign algn_vld = tag_vld_q[SBOX_LAT-1];
            assign algn_own = tag_own_q[SBOX_LAT-1];
        end
    endgenerate

    always_comb begin
        keyexp_result_d = keyexp_result_q;
        sbytes_result_d = sbytes_result_q;
        if (algn_vld && !clear) begin
            if (algn_own == OWN_SBYTES) sbytes_result_d = sbox_out;
            else                        keyexp_result_d = sbox_out;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            tag_vld_q       <= '0;
            tag_own_q       <= '0;
            keyexp_result_q <= '0;
            sbytes_result_q <= '0;
        end else begin
            tag_vld_q       <= tag_vld_d;
            tag_own_q       <= tag_own_d;
            keyexp_result_q <= keyexp_result_d;
            sbytes_result_q <= sbytes_result_d;
        end
    end

    always_comb begin
        keyexp_valid  = tag_vld_q[SBOX_LAT] && (tag_own_q[SBOX_LAT] == OWN_KEYEXP);
        sbytes_valid  = tag_vld_q[SBOX_LAT] && (tag_own_q[SBOX_LAT] == OWN_SBYTES);
        keyexp_result = keyexp_result_q;
        sbytes_result = sbytes_result_q;
        busy          = |tag_vld_q;
    end

endmodule

// File: tb/tb_sbox_arbiter.sv
// Directed bench for sbox_arbiter: one SBOX_LAT=1 instance driven from a vector table,
// plus SBOX_LAT=0 and SBOX_LAT=4 instances for the latency sweep.
module tb_sbox_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic n_rst, clr;
    int   checks   = 0;
    int   failures = 0;

    // Stand-in S-box: any bijection works; this one maps 00010203 to 637c777b like AES.
    function automatic logic [31:0] sb(input logic [31:0] w);
        return w ^ 32'h637d7578;
    endfunction

    // Main instance, SBOX_LAT=1
    logic        k_req, s_req;
    logic [31:0] k_word, s_word;
    logic        m_kgnt, m_kvld, m_sgnt, m_svld, m_busy;
    logic [31:0] m_kres, m_sres, m_sbin, m_sbout, sb1_q;

    always @(posedge clk) sb1_q <= sb(m_sbin);
    assign m_sbout = sb1_q;

    sbox_arbiter #(.SBOX_LAT(1)) u_dut (
        .clk(clk), .n_rst(n_rst), .clear(clr),
        .keyexp_req(k_req), .keyexp_word(k_word), .keyexp_gnt(m_kgnt),
        .keyexp_valid(m_kvld), .keyexp_result(m_kres),
        .sbytes_req(s_req), .sbytes_word(s_word), .sbytes_gnt(m_sgnt),
        .sbytes_valid(m_svld), .sbytes_result(m_sres),
        .sbox_in(m_sbin), .sbox_out(m_sbout), .busy(m_busy)
    );

    // Sweep instances share sub_bytes stimulus
    logic        sw_req, zero_req;
    logic [31:0] sw_word, zero_word;
    logic        z_kgnt, z_kvld, z_sgnt, z_svld, z_busy;
    logic [31:0] z_kres, z_sres, z_sbin, z_sbout;
    logic        f_kgnt, f_kvld, f_sgnt, f_svld, f_busy;
    logic [31:0] f_kres, f_sres, f_sbin, f_sbout;
    logic [31:0] p4 [4];

    assign z_sbout = sb(z_sbin);
    always @(posedge clk) begin
        p4[0] <= sb(f_sbin);
        p4[1] <= p4[0];
        p4[2] <= p4[1];
        p4[3] <= p4[2];
    end
    assign f_sbout = p4[3];

    sbox_arbiter #(.SBOX_LAT(0)) u_lat0 (
        .clk(clk), .n_rst(n_rst), .clear(clr),
        .keyexp_req(zero_req), .keyexp_word(zero_word), .keyexp_gnt(z_kgnt),
        .keyexp_valid(z_kvld), .keyexp_result(z_kres),
        .sbytes_req(sw_req), .sbytes_word(sw_word), .sbytes_gnt(z_sgnt),
        .sbytes_valid(z_svld), .sbytes_result(z_sres),
        .sbox_in(z_sbin), .sbox_out(z_sbout), .busy(z_busy)
    );

    sbox_arbiter #(.SBOX_LAT(4)) u_lat4 (
        .clk(clk), .n_rst(n_rst), .clear(clr),
        .keyexp_req(zero_req), .keyexp_word(zero_word), .keyexp_gnt(f_kgnt),
        .keyexp_valid(f_kvld), .keyexp_result(f_kres),
        .sbytes_req(sw_req), .sbytes_word(sw_word), .sbytes_gnt(f_sgnt),
        .sbytes_valid(f_svld), .sbytes_result(f_sres),
        .sbox_in(f_sbin), .sbox_out(f_sbout), .busy(f_busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        kreq;
        logic [31:0] kword;
        logic        sreq;
        logic [31:0] sword;
        logic        clr;
        logic        kgnt, sgnt, kvld, svld, busy;
        logic [31:0] sbin, kres, sres;
    } vec_t;

    function automatic vec_t mk(input logic kreq, input logic [31:0] kword,
                                input logic sreq, input logic [31:0] sword, input logic cl,
                                input logic kg, input logic sg, input logic kv, input logic sv,
                                input logic bz, input logic [31:0] sbin,
                                input logic [31:0] kr, input logic [31:0] sr);
        vec_t v;
        v.kreq = kreq; v.kword = kword; v.sreq = sreq; v.sword = sword; v.clr = cl;
        v.kgnt = kg; v.sgnt = sg; v.kvld = kv; v.svld = sv; v.busy = bz;
        v.sbin = sbin; v.kres = kr; v.sres = sr;
        return v;
    endfunction

    function automatic logic [31:0] sweep_word(input int t);
        return 32'h1000_0000 | (32'(t) * 32'h0011_0101);
    endfunction

    localparam logic [31:0] W1  = 32'h00010203, W2  = 32'h11223344, W3  = 32'h55667788;
    localparam logic [31:0] W4  = 32'h99aabbcc, W5  = 32'hddeeff00, W6  = 32'h0badcafe;
    localparam logic [31:0] W7  = 32'hdeadbeef, W8  = 32'h01234567, W9  = 32'h89abcdef;
    localparam logic [31:0] W10 = 32'hfedcba98, W11 = 32'h76543210, W12 = 32'hcafef00d;

    vec_t        vt [21];
    logic [31:0] lastk, lasts;

    initial begin
        n_rst = 1'b0; clr = 1'b0;
        k_req = 1'b0; k_word = '0; s_req = 1'b0; s_word = '0;
        sw_req = 1'b0; sw_word = '0; zero_req = 1'b0; zero_word = '0;

        // idle, then contention, single lookup, abort
        vt[0] = mk(0, 0, 0, 0, 0,   0, 0, 0, 0, 0,  0, 0, 0);
`ifdef SBOX_RR_EN
        vt[1] = mk(1, W2, 1, W6, 0, 1, 0, 0, 0, 0,  W2, 0, 0);
        vt[2] = mk(1, W3, 1, W6, 0, 0, 1, 0, 0, 1,  W6, 0, 0);
        vt[3] = mk(1, W3, 1, W7, 0, 1, 0, 1, 0, 1,  W3, sb(W2), 0);
        vt[4] = mk(1, W4, 1, W7, 0, 0, 1, 0, 1, 1,  W7, sb(W2), sb(W6));
        vt[5] = mk(1, W4, 0, 0, 0,  1, 0, 1, 0, 1,  W4, sb(W3), sb(W6));
        vt[6] = mk(0, 0, 0, 0, 0,   0, 0, 0, 1, 1,  0, sb(W3), sb(W7));
        vt[7] = mk(0, 0, 0, 0, 0,   0, 0, 1, 0, 1,  0, sb(W4), sb(W7));
        lastk = sb(W4);
        lasts = sb(W7);
`else
        vt[1] = mk(1, W2, 1, W6, 0, 1, 0, 0, 0, 0,  W2, 0, 0);
        vt[2] = mk(1, W3, 1, W6, 0, 1, 0, 0, 0, 1,  W3, 0, 0);
        vt[3] = mk(1, W4, 1, W6, 0, 1, 0, 1, 0, 1,  W4, sb(W2), 0);
        vt[4] = mk(1, W5, 1, W6, 0, 1, 0, 1, 0, 1,  W5, sb(W3), 0);
        vt[5] = mk(0, 0, 1, W6, 0,  0, 1, 1, 0, 1,  W6, sb(W4), 0);
        vt[6] = mk(0, 0, 0, 0, 0,   0, 0, 1, 0, 1,  0, sb(W5), 0);
        vt[7] = mk(0, 0, 0, 0, 0,   0, 0, 0, 1, 1,  0, sb(W5), sb(W6));
        lastk = sb(W5);
        lasts = sb(W6);
`endif
        vt[8]  = mk(0, 0, 0, 0, 0,   0, 0, 0, 0, 0,  0, lastk, lasts);
        vt[9]  = mk(1, W1, 0, 0, 0,  1, 0, 0, 0, 0,  W1, lastk, lasts);
        vt[10] = mk(0, 0, 0, 0, 0,   0, 0, 0, 0, 1,  0, lastk, lasts);
        vt[11] = mk(0, 0, 0, 0, 0,   0, 0, 1, 0, 1,  0, 32'h637c777b, lasts);
        vt[12] = mk(0, 0, 0, 0, 0,   0, 0, 0, 0, 0,  0, sb(W1), lasts);
        vt[13] = mk(1, W8, 0, 0, 0,  1, 0, 0, 0, 0,  W8, sb(W1), lasts);
        vt[14] = mk(1, W9, 0, 0, 0,  1, 0, 0, 0, 1,  W9, sb(W1), lasts);
        vt[15] = mk(1, W10, 0, 0, 0, 1, 0, 1, 0, 1,  W10, sb(W8), lasts);
        vt[16] = mk(1, W11, 0, 0, 1, 0, 0, 1, 0, 1,  0, sb(W9), lasts);
        vt[17] = mk(1, W11, 0, 0, 0, 1, 0, 0, 0, 0,  W11, sb(W9), lasts);
        vt[18] = mk(0, 0, 0, 0, 0,   0, 0, 0, 0, 1,  0, sb(W9), lasts);
        vt[19] = mk(0, 0, 0, 0, 0,   0, 0, 1, 0, 1,  0, sb(W11), lasts);
        vt[20] = mk(0, 0, 0, 0, 0,   0, 0, 0, 0, 0,  0, sb(W11), lasts);

        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        #1;
        chk("rst_kgnt", 32'(m_kgnt), 0);
        chk("rst_sgnt", 32'(m_sgnt), 0);
        chk("rst_kvld", 32'(m_kvld), 0);
        chk("rst_svld", 32'(m_svld), 0);
        chk("rst_kres", m_kres, 0);
        chk("rst_sres", m_sres, 0);
        chk("rst_busy", 32'(m_busy), 0);
        chk("rst_sbin", m_sbin, 0);

        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            k_req = vt[i].kreq; k_word = vt[i].kword;
            s_req = vt[i].sreq; s_word = vt[i].sword;
            clr   = vt[i].clr;
            #1;
            chk($sformatf("r%0d_kgnt", i), 32'(m_kgnt), 32'(vt[i].kgnt));
            chk($sformatf("r%0d_sgnt", i), 32'(m_sgnt), 32'(vt[i].sgnt));
            chk($sformatf("r%0d_kvld", i), 32'(m_kvld), 32'(vt[i].kvld));
            chk($sformatf("r%0d_svld", i), 32'(m_svld), 32'(vt[i].svld));
            chk($sformatf("r%0d_busy", i), 32'(m_busy), 32'(vt[i].busy));
            chk($sformatf("r%0d_sbin", i), m_sbin, vt[i].sbin);
            chk($sformatf("r%0d_kres", i), m_kres, vt[i].kres);
            chk($sformatf("r%0d_sres", i), m_sres, vt[i].sres);
        end

        // Reset asserted while a lookup is in flight
        @(negedge clk);
        k_req = 1'b1; k_word = W12;
        #1 chk("mr_gnt", 32'(m_kgnt), 1);
        @(negedge clk);
        k_req = 1'b0; k_word = '0;
        #1 chk("mr_busy_pre", 32'(m_busy), 1);
        #1 n_rst = 1'b0;
        #1;
        chk("mr_busy", 32'(m_busy), 0);
        chk("mr_kres", m_kres, 0);
        chk("mr_sres", m_sres, 0);
        @(negedge clk);
        n_rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            chk($sformatf("mr%0d_kvld", c), 32'(m_kvld), 0);
            chk($sformatf("mr%0d_busy", c), 32'(m_busy), 0);
            chk($sformatf("mr%0d_kres", c), m_kres, 0);
        end

        // Latency sweep: 8 back-to-back sub_bytes lookups on LAT=0 and LAT=4
        for (int t = 0; t < 15; t++) begin
            @(negedge clk);
            sw_req  = (t < 8);
            sw_word = (t < 8) ? sweep_word(t) : '0;
            #1;
            if (t < 8) begin
                chk($sformatf("sw%0d_gnt0", t), 32'(z_sgnt), 1);
                chk($sformatf("sw%0d_gnt4", t), 32'(f_sgnt), 1);
                chk($sformatf("sw%0d_sbin4", t), f_sbin, sweep_word(t));
            end
            chk($sformatf("sw%0d_vld0", t), 32'(z_svld), 32'(t >= 1 && t <= 8));
            chk($sformatf("sw%0d_vld4", t), 32'(f_svld), 32'(t >= 5 && t <= 12));
            chk($sformatf("sw%0d_kvld0", t), 32'(z_kvld), 0);
            if (t >= 1 && t <= 8)
                chk($sformatf("sw%0d_res0", t), z_sres, sb(sweep_word(t - 1)));
            if (t >= 5 && t <= 12)
                chk($sformatf("sw%0d_res4", t), f_sres, sb(sweep_word(t - 5)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
